// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// operand width, RV32M op codes, FSM states and two's-complement helpers.
package muldiv_sequencer_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN) + 1;

    // funct7 value that marks an OP-format instruction as M-extension.
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Two's-complement negation of an operand-width value.
    function automatic logic [XLEN-1:0] negate_x(input logic [XLEN-1:0] v);
        return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation of a full double-width product.
    function automatic logic [2*XLEN-1:0] negate_2x(input logic [2*XLEN-1:0] v);
        return (~v) + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage request/response bundle between the pipeline and the
// multiply/divide sequencer.
interface muldiv_sequencer_if;
    import muldiv_sequencer_pkg::*;

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, rs1_val, rs2_val, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, rs1_val, rs2_val, flush,
        output busy, done, result
    );

endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M unit: shift-add multiplier / restoring divider working on
// operand magnitudes for XLEN cycles, followed by a sign-fix cycle. Divide
// special cases (by zero, signed overflow) complete on a one-cycle fast path.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    muldiv_sequencer_if.slave   bus
);

    state_e              state_q, state_d;
    op_e                 op_q;
    logic                s1_q, s2_q;
    logic [XLEN-1:0]     b_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [CNT_W-1:0]    count_q;
    logic [XLEN-1:0]     result_q;

    op_e                 op_in;
    logic                neg_a, neg_b;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                can_accept, accept;
    logic                div_zero, div_ovf, fast;
    logic [XLEN-1:0]     fast_result;
    logic [2*XLEN-1:0]   acc_step;
    logic [XLEN-1:0]     fix_result;

    assign op_in = op_e'(bus.funct3);

    // Decode the incoming op: sign handling, magnitudes and fast-path cases.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        neg_a       = 1'b0;
        neg_b       = 1'b0;
        fast_result = bus.rs1_val;
        if (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM})
            neg_a = bus.rs1_val[XLEN-1];
        if (op_in inside {OP_MULH, OP_DIV, OP_REM})
            neg_b = bus.rs2_val[XLEN-1];
        a_mag      = neg_a ? negate_x(bus.rs1_val) : bus.rs1_val;
        b_mag      = neg_b ? negate_x(bus.rs2_val) : bus.rs2_val;
        can_accept = (state_q == ST_IDLE || state_q == ST_DONE) && !bus.flush;
        accept     = bus.start && can_accept;
        div_zero   = bus.funct3[2] && (bus.rs2_val == '0);
        div_ovf    = (op_in == OP_DIV || op_in == OP_REM)
                     && (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                     && (bus.rs2_val == '1);
        fast       = div_zero || div_ovf;
        // Quotients by zero are all-ones, overflow remainder is zero; every
        // other fast-path answer is rs1 itself.
        if (div_zero && !bus.funct3[1])
            fast_result = '1;
        else if (div_ovf && bus.funct3[1])
            fast_result = '0;
    end

    // One multiply or divide iteration, plus the final sign correction.
    always_comb begin
        logic [XLEN:0]     mul_sum;
        logic [XLEN:0]     rem_sh;
        logic [XLEN:0]     rem_diff;
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quot, rem;

        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : '0)};
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, b_q};
        if (op_q[2])
            acc_step = rem_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            acc_step = {mul_sum, acc_q[XLEN-1:1]};

        prod = (s1_q ^ s2_q) ? negate_2x(acc_q) : acc_q;
        quot = (s1_q ^ s2_q) ? negate_x(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
        rem  = s1_q ? negate_x(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       fix_result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_result = quot;
            default:                      fix_result = rem;
        endcase
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept)
                    state_d = fast ? ST_DONE : ST_CALC;
                else
                    state_d = ST_IDLE;
            end
            ST_CALC: if (count_q == CNT_W'(XLEN-1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.flush)
            state_d = ST_IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers
        // update together from values sampled at the same edge.
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OP_MUL;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            b_q      <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q    <= op_in;
            s1_q    <= neg_a;
            s2_q    <= neg_b;
            b_q     <= b_mag;
            acc_q   <= {{XLEN{1'b0}}, a_mag};
            count_q <= '0;
            if (fast)
                result_q <= fast_result;
        end else if (!bus.flush) begin
            if (state_q == ST_CALC) begin
                acc_q   <= acc_step;
                count_q <= count_q + CNT_W'(1);
            end
            if (state_q == ST_FIX)
                result_q <= fix_result;
        end
    end

    assign bus.busy   = (accept && !fast) || (state_q == ST_CALC) || (state_q == ST_FIX);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: a reference model computes each
// expected result and done cycle at issue time; a monitor pops and compares.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    muldiv_sequencer_if bus();

    muldiv_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model built on the simulator's own arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb_, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'b001: begin p = sa * sb_; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb_; return p[31:0];
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb_; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_res"}, bus.result, e.res);
                check({e.tag, "_cyc"}, cyc, e.cyc);
                last_res = e.res;
            end
        end
    end

    // Called just after a falling edge: drives one start cycle, records the
    // expectation (if tracked) and checks busy in the accept cycle.
    task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input bit track, output bit fast);
        exp_t e;
        fast = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        bus.start   = 1'b1;
        bus.funct3  = f;
        bus.rs1_val = a;
        bus.rs2_val = b;
        if (track) begin
            e.res = model(f, a, b);
            e.cyc = cyc + (fast ? 1 : XLEN + 2);
            e.tag = tag;
            sb.push_back(e);
        end
        #1 check({tag, "_busy_t"}, bus.busy, {63'b0, !fast});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, sb.size(), 0);
    endtask

    task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b);
        bit fast;
        @(negedge clk);
        issue(tag, f, a, b, 1'b1, fast);
        check({tag, "_busy_t1"}, bus.busy, {63'b0, !fast});
        drain(tag);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        bit fast;
        bus.start   = 1'b0;
        bus.flush   = 1'b0;
        bus.funct3  = '0;
        bus.rs1_val = '0;
        bus.rs2_val = '0;
        reset       = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_result", bus.result, 0);
        reset = 1'b0;

        // MUL with full busy window and a start pulse during CALC that must be ignored.
        @(negedge clk);
        c = cyc;
        issue("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 1'b1, fast);
        while (cyc < c + 34) begin
            bus.start   = (cyc == c + 5);
            bus.funct3  = 3'b100;
            bus.rs1_val = 32'd1;
            bus.rs2_val = 32'd0;
            #1 check("mul_busy", bus.busy, 1);
            @(negedge clk);
        end
        bus.start = 1'b0;
        #1 check("mul_busy_done", bus.busy, 0);
        drain("mul");

        run("mulhu",  3'b011, 32'd7,         32'hFFFF_FFFD);
        run("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000);
        run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("divu",   3'b101, 32'd100,       32'd7);
        run("remu",   3'b111, 32'd100,       32'd7);
        run("div",    3'b100, 32'hFFFF_FF9C, 32'd7);
        run("rem",    3'b110, 32'hFFFF_FF9C, 32'd7);
        run("div0",   3'b100, 32'd5,         32'd0);
        run("remu0",  3'b111, 32'd5,         32'd0);
        run("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        run("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        run("mulhsu2", 3'b010, 32'h0000_0003, 32'h8000_0001);
        run("rem_neg_div", 3'b110, 32'd17, 32'hFFFF_FFFB);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            logic [2:0]  f;
            a = $urandom;
            b = (i == 3) ? 32'd0 : $urandom;
            f = 3'($urandom_range(0, 7));
            run("rand", f, a, b);
        end

        // Flush mid-divide: no done, result held, next op runs cleanly.
        @(negedge clk);
        c = cyc;
        issue("div_fl", 3'b100, 32'd1000, 32'd3, 1'b0, fast);
        while (cyc < c + 10) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1 check("flush_busy", bus.busy, 0);
        check("flush_result", bus.result, {32'b0, last_res});
        @(negedge clk);
        issue("mul_after_flush", 3'b000, 32'd12345, 32'd678, 1'b1, fast);
        drain("mul_after_flush");

        // Same again with reset in place of flush: result clears.
        @(negedge clk);
        c = cyc;
        issue("div_rst", 3'b101, 32'd1000, 32'd3, 1'b0, fast);
        while (cyc < c + 10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 check("reset_busy", bus.busy, 0);
        check("reset_result", bus.result, 0);
        @(negedge clk);
        issue("mul_after_rst", 3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, fast);
        drain("mul_after_rst");

        // Back-to-back: second start lands in the first op's DONE cycle.
        @(negedge clk);
        c = cyc;
        issue("b2b1", 3'b100, 32'hFFFF_FF9C, 32'd7, 1'b1, fast);
        while (cyc < c + 34) @(negedge clk);
        issue("b2b2", 3'b001, 32'h8000_0000, 32'h8000_0000, 1'b1, fast);
        drain("b2b");

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
